tcp_rx_dispatch: RTL
====================

TCP_RX_DISPATCH -- requirements
Module: tcp_rx_dispatch

Interface
REQ-001 SHALL have parameter NUM_TCP, default 8, number of TCP stream channels (1..32).
REQ-002 SHALL have parameter PORT_W, default 16, TCP port width.
REQ-003 SHALL have parameter CNT_W, default 16, drop counter width.
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  clock; all logic on rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 s_tdata  in  8  TCP segment byte (byte 0 = source port MSB).
REQ-008 s_tvalid  in  1  input byte valid.
REQ-009 s_tready  out  1  input byte accepted when high with s_tvalid.
REQ-010 s_tlast  in  1  last byte of segment.
REQ-011 i_port  in  NUM_TCP*PORT_W  per-channel local port; channel i at [PORT_W*i +: PORT_W].
REQ-012 i_port_en  in  NUM_TCP  per-channel port-table entry enable.
REQ-013 m_tdata  out  8  output byte, shared by all channels.
REQ-014 m_tlast  out  1  output last, shared.
REQ-015 m_tvalid  out  NUM_TCP  per-channel valid; at most one bit high.
REQ-016 m_tready  in  NUM_TCP  per-channel ready.
REQ-017 o_drop_count  out  CNT_W  saturating count of dropped segments.
REQ-018 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, HDR, LOOKUP, REPLAY, PASS, DROP.
REQ-020 IDLE/HDR: s_tready=1; each accepted byte is stored in 4-byte buffer at index 0..3; IDLE goes to HDR on first accepted byte.
REQ-021 Dest port SHALL be {byte2, byte3}; on acceptance of byte 3 without s_tlast the state SHALL go to LOOKUP.
REQ-022 s_tlast accepted at byte index 0..2 (short segment): segment discarded, o_drop_count incremented, state to IDLE next cycle.
REQ-023 s_tlast accepted at byte 3 SHALL be stored with the buffer; lookup proceeds normally.
REQ-024 LOOKUP lasts exactly one cycle with s_tready=0; match = i_port_en[i] && i_port[i]==dest; selected channel = lowest matching index, registered.
REQ-025 Port table SHALL be sampled only in LOOKUP; changes afterwards do not affect the current segment.
REQ-026 Match: go to REPLAY; no match: increment o_drop_count, go to DROP (or IDLE if byte 3 was last).
REQ-027 REPLAY: present buffered bytes 0..3 in order, m_tvalid[sel]=1, s_tready=0; advance on m_tready[sel]; m_tlast=1 only on byte 3 if stored last.
REQ-028 After byte 3 handshake: to IDLE if stored last, else PASS.
REQ-029 PASS: combinational pass-through; m_tdata=s_tdata, m_tlast=s_tlast, m_tvalid[sel]=s_tvalid, s_tready=m_tready[sel]; handshake with s_tlast goes to IDLE.
REQ-030 DROP: s_tready=1, all m_tvalid=0; accepted s_tlast goes to IDLE; counter not incremented again.
REQ-031 o_drop_count SHALL saturate at all-ones; no wrap.
REQ-032 m_tvalid SHALL not deassert before handshake once asserted in REPLAY; m_tdata/m_tlast stable while stalled.
REQ-033 Zero-latency back-to-back: IDLE accepts a new segment's byte 0 in the cycle after the previous segment's last handshake.

Reset
REQ-034 On i_rst: state=IDLE, buffer index=0, sel=0, o_drop_count=0, m_tvalid=0, o_busy=0; s_tready=1 from the first cycle after reset.
REQ-035 Reset mid-segment SHALL abandon the segment silently (no count); following bytes are treated as a new segment's byte 0.

Verification
REQ-036 Port table ch3=0x1F90 en; 10-byte segment dest 0x1F90, m_tready all 1 -> 10 bytes on ch3 in order, last on byte 9, drop count 0.
REQ-037 ch1 and ch5 both 0x0050 enabled; segment to 0x0050 -> delivered on ch1 only; ch1 disabled -> delivered on ch5.
REQ-038 Segment to unmatched port 0x1234, 20 bytes -> all 20 consumed with s_tready=1, no m_tvalid, drop count 1; 3-byte short segment -> drop count 2.
REQ-039 CNT_W=2, 5 unmatched segments -> o_drop_count stays 3.
REQ-040 m_tready[sel] toggling randomly during REPLAY and PASS -> byte order and data intact, m_tdata stable during stalls, no byte loss.
REQ-041 i_rst asserted after byte 6 of a matched segment -> m_tvalid=0, o_busy=0, count 0; next full segment routes correctly.

Source files
------------

// File: rtl/tcp_rx_dispatch.sv
// TCP receive dispatcher: buffers the 4-byte port header, looks up the destination
// port in a per-channel table, then replays the header and passes the rest through.
module tcp_rx_dispatch #(
    parameter int NUM_TCP = 8,
    parameter int PORT_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [7:0]                s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic                      s_tlast,
    input  logic [NUM_TCP*PORT_W-1:0] i_port,
    input  logic [NUM_TCP-1:0]        i_port_en,
    output logic [7:0]                m_tdata,
    output logic                      m_tlast,
    output logic [NUM_TCP-1:0]        m_tvalid,
    input  logic [NUM_TCP-1:0]        m_tready,
    output logic [CNT_W-1:0]          o_drop_count,
    output logic                      o_busy
);

    localparam int SEL_W = (NUM_TCP > 1) ? $clog2(NUM_TCP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOOKUP,
        REPLAY,
        PASS,
        DROP
    } state_t;

    state_t             state_reg;
    logic [7:0]         hdr_reg [0:3];
    logic [1:0]         idx_reg;
    logic               last_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [CNT_W-1:0]   drop_cnt_reg;

    logic [PORT_W-1:0]  dest_port;
    logic [NUM_TCP-1:0] port_match;
    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               ready_sel;
    logic               chan_valid;
    logic               s_accept;
    logic               m_accept;
    logic [CNT_W-1:0]   drop_cnt_next;

    assign dest_port = PORT_W'({hdr_reg[2], hdr_reg[3]});

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TCP; gi++) begin : g_match
            assign port_match[gi] = i_port_en[gi] &&
                                    (i_port[PORT_W*gi +: PORT_W] == dest_port);
        end
    endgenerate

    // Scan from the top so the lowest matching channel wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_TCP - 1; i >= 0; i--) begin
            if (port_match[i]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign ready_sel = m_tready[sel_reg];

    always_comb begin
        s_tready   = 1'b0;
        chan_valid = 1'b0;
        m_tdata    = 8'h00;
        m_tlast    = 1'b0;
        case (state_reg)
            IDLE, HDR, DROP: s_tready = 1'b1;
            REPLAY: begin
                chan_valid = 1'b1;
                m_tdata    = hdr_reg[idx_reg];
                m_tlast    = (idx_reg == 2'd3) && last_reg;
            end
            PASS: begin
                s_tready   = ready_sel;
                chan_valid = s_tvalid;
                m_tdata    = s_tdata;
                m_tlast    = s_tlast;
            end
            default: s_tready = 1'b0;
        endcase
    end

    generate
        for (gi = 0; gi < NUM_TCP; gi++) begin : g_valid
            assign m_tvalid[gi] = chan_valid && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign s_accept      = s_tvalid && s_tready;
    assign m_accept      = chan_valid && ready_sel;
    assign drop_cnt_next = (&drop_cnt_reg) ? drop_cnt_reg : drop_cnt_reg + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            idx_reg      <= 2'd0;
            last_reg     <= 1'b0;
            sel_reg      <= '0;
            drop_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, HDR: begin
                    if (s_accept) begin
                        hdr_reg[idx_reg] <= s_tdata;
                        if (idx_reg == 2'd3) begin
                            last_reg  <= s_tlast;
                            idx_reg   <= 2'd0;
                            state_reg <= LOOKUP;
                        end else if (s_tlast) begin
                            // Too short to carry a destination port.
                            idx_reg      <= 2'd0;
                            drop_cnt_reg <= drop_cnt_next;
                            state_reg    <= IDLE;
                        end else begin
                            idx_reg   <= idx_reg + 2'd1;
                            state_reg <= HDR;
                        end
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        sel_reg   <= hit_idx;
                        state_reg <= REPLAY;
                    end else begin
                        drop_cnt_reg <= drop_cnt_next;
                        state_reg    <= last_reg ? IDLE : DROP;
                    end
                end
                REPLAY: begin
                    if (m_accept) begin
                        if (idx_reg == 2'd3) begin
                            idx_reg   <= 2'd0;
                            state_reg <= last_reg ? IDLE : PASS;
                        end else begin
                            idx_reg <= idx_reg + 2'd1;
                        end
                    end
                end
                PASS: begin
                    if (m_accept && s_tlast) state_reg <= IDLE;
                end
                DROP: begin
                    if (s_accept && s_tlast) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_drop_count = drop_cnt_reg;
    assign o_busy       = (state_reg != IDLE);

endmodule
